axis_frame_replayer: RTL
========================

# axis_frame_replayer

Synthesizable, parametrised AXI4-Stream frame source that replays a preloaded frame of NUM_PACKETS × DATAPOINTS words into an accelerator's slave stream interface. It inserts configurable inter-packet gaps, marks TLAST per frame or per packet, and waits for the accelerator's output TLAST before re-arming. In looped mode it replays the frame continuously. It sits on-chip in front of `axis_wrapper_top` for hardware-in-the-loop throughput runs, where no host-driven testbench is available.

## Interface
- DATA_WIDTH, 64: stream word width in bits; must be a multiple of 8.
- DATAPOINTS, 10: words per packet; must be ≥ 1.
- NUM_PACKETS, 13: packets per frame; must be ≥ 1. DEPTH = DATAPOINTS*NUM_PACKETS.
- GAP_CYCLES, 12: idle cycles inserted after each non-final packet. 0 disables gaps.
- TLAST_PER_PACKET, 0: 0 asserts TLAST on the final frame word only; 1 asserts it on every packet's last word.
- axis_aclk  in  1  sole clock, rising edge.
- axis_areset  in  1  synchronous, active-high reset.
- wr_en  in  1  frame-memory write strobe.
- wr_addr  in  clog2(DEPTH)  write word index.
- wr_data  in  DATA_WIDTH  write word.
- start  in  1  begin a frame (one-cycle pulse or level).
- loop_en  in  1  replay again after each acknowledged frame.
- stop_req  in  1  finish the current frame, then go idle.
- rx_tlast  in  1  accelerator output beat with TLAST&TVALID&TREADY.
- m_axis_tdata  out  DATA_WIDTH  mem[rd_ptr].
- m_axis_tstrb  out  DATA_WIDTH/8  all ones.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  end marker.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  state ≠ IDLE.
- run_count  out  16  completed (acknowledged) frames, wraps.

## Operation
- Frame memory: DEPTH × DATA_WIDTH array with asynchronous read at rd_ptr. Contents are not cleared by reset. wr_en is accepted only in IDLE and ignored otherwise.
- The block uses two counters:
  - rd_ptr, 0..DEPTH-1, resets to 0 at frame start.
  - pkt_cnt, 0..DATAPOINTS-1, wraps at the packet end.
- A beat is a cycle with m_axis_tvalid & m_axis_tready. On each beat rd_ptr and pkt_cnt advance.
- The state machine has four states:
  - IDLE: tvalid=0. On start go to STREAM with rd_ptr=0, pkt_cnt=0, rx_seen=0.
  - STREAM: tvalid=1.
    - Beat on the frame's last word (rd_ptr=DEPTH-1): go to WAIT_RX.
    - Beat on a packet's last word (pkt_cnt=DATAPOINTS-1) with GAP_CYCLES>0: go to GAP and load gap_cnt=GAP_CYCLES-1.
    - Otherwise stay in STREAM.
  - GAP: tvalid=0. gap_cnt decrements each cycle. At 0, go to STREAM.
  - WAIT_RX: tvalid=0. When rx_seen|rx_tlast, increment run_count.
    - If loop_en & !stop_latched: go to STREAM, rd_ptr=0, rx_seen=0.
    - Otherwise go to IDLE.
- TLAST:
  - Always 1 when rd_ptr=DEPTH-1.
  - Also 1 when pkt_cnt=DATAPOINTS-1 if TLAST_PER_PACKET=1.
  - Only meaningful while tvalid=1.
- rx_seen: sticky. Set by rx_tlast in STREAM, GAP or WAIT_RX (the accelerator may finish early). Cleared on frame restart. rx_tlast in IDLE is ignored.
- stop_latched: set by stop_req while busy, cleared in IDLE. It prevents the loop from re-arming but never truncates a frame.
- start while busy is ignored.
- AXIS rule: once tvalid=1 it stays 1, with tdata and tlast stable, until a beat.
- Degenerate parameters:
  - DEPTH=1: the single word carries TLAST.
  - DATAPOINTS=1 with GAP_CYCLES>0: every beat except the final one is followed by a gap.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=mem[0] (don't-care), busy=0, run_count=0, state IDLE, rd_ptr=0, all flags 0.
- start sampled in IDLE at edge N: tvalid=1 with word 0 from cycle N+1.
- Back-to-back beats have zero bubbles, one word per cycle with tready held high.
- Packet gap: with a beat on a packet end at edge N, tvalid is low for exactly GAP_CYCLES cycles, N+1..N+GAP_CYCLES, and high again at N+GAP_CYCLES+1.
- Final beat at edge N: tvalid=0 from N+1.
- WAIT_RX exit on rx_seen or rx_tlast at edge M:
  - run_count updates at M+1.
  - On loop, tvalid=1 with word 0 at M+1.
- The earliest restart is one cycle after the final beat, when rx_seen is already set.
- Reset asserted mid-frame: outputs take reset values at the next edge and the frame is abandoned. Memory is retained.

## Test plan
- Load 130 words with mem[i]=i, start, tready=1, no rx_tlast: 13 packets of 10 consecutive beats, each followed by 12 idle cycles (no gap after the final packet). TLAST only on data 129. busy stays 1 and run_count=0.
- Same run with rx_tlast pulsed 5 cycles after the final beat, loop_en=1: run_count=1 and word 0 is re-presented on the cycle after the pulse. Then assert stop_req mid-second-frame: the frame completes, and after the next rx_tlast run_count=2, busy=0, tvalid=0.
- Random tready, 50% duty: tdata and tlast hold stable while tvalid & !tready. The received sequence is exactly 0..129. Gap length is counted from the packet-end beat.
- TLAST_PER_PACKET=1, GAP_CYCLES=0: TLAST on data 9, 19, …, 129 and no idle cycles between packets.
- rx_tlast pulsed during packet 3: after the final beat, the frame restarts in 1 cycle (rx_seen). rx_tlast pulsed in IDLE: no effect.
- wr_en and start while busy are ignored, and memory is unchanged afterwards. Reset at word 57: tvalid=0 next cycle; a fresh start replays from word 0.

Source files
------------

// File: rtl/axis_frame_replayer.sv
// AXI4-Stream frame source. It replays a preloaded frame of NUM_PACKETS x DATAPOINTS words,
// inserts inter-packet gaps, and re-arms after the accelerator acknowledges with its output TLAST.
module axis_frame_replayer #(
    parameter int DATA_WIDTH       = 64,
    parameter int DATAPOINTS       = 10,
    parameter int NUM_PACKETS      = 13,
    parameter int GAP_CYCLES       = 12,
    parameter int TLAST_PER_PACKET = 0,
    localparam int DEPTH           = DATAPOINTS * NUM_PACKETS,
    localparam int AW              = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    start,
    input  logic                    loop_en,
    input  logic                    stop_req,
    input  logic                    rx_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic [15:0]             run_count
);

    localparam int PW = (DATAPOINTS > 1) ? $clog2(DATAPOINTS) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PKT  = PW'(DATAPOINTS - 1);
    localparam logic [GW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_GAP,
        S_WAIT_RX
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_pkt_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic                  r_rx_seen;
    logic                  r_stop_latched;
    logic [15:0]           r_run_count;

    logic w_frame_end;
    logic w_pkt_end;
    logic w_ack;
    logic w_beat;
    logic w_restart;
    logic w_load_gap;

    assign w_frame_end = (r_rd_ptr == LAST_ADDR);
    assign w_pkt_end   = (r_pkt_cnt == LAST_PKT);
    assign w_ack       = r_rx_seen | rx_tlast;

    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_restart   = 1'b0;
        w_load_gap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_STREAM;
                    w_restart   = 1'b1;
                end
            end
            S_STREAM: begin
                if (m_axis_tready) begin
                    w_beat = 1'b1;
                    // Frame end takes priority so the final packet never gets a gap.
                    if (w_frame_end) begin
                        w_state_nxt = S_WAIT_RX;
                    end else if (w_pkt_end && (GAP_CYCLES > 0)) begin
                        w_state_nxt = S_GAP;
                        w_load_gap  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_WAIT_RX: begin
                if (w_ack) begin
                    if (loop_en && !r_stop_latched) begin
                        w_state_nxt = S_STREAM;
                        w_restart   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state        <= S_IDLE;
            r_rd_ptr       <= '0;
            r_pkt_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_rx_seen      <= 1'b0;
            r_stop_latched <= 1'b0;
            r_run_count    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_restart) begin
                r_rd_ptr  <= '0;
                r_pkt_cnt <= '0;
            end else if (w_beat) begin
                r_rd_ptr  <= w_frame_end ? '0 : r_rd_ptr + 1'b1;
                r_pkt_cnt <= w_pkt_end ? '0 : r_pkt_cnt + 1'b1;
            end

            if (w_load_gap) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end

            if (w_restart) begin
                r_rx_seen <= 1'b0;
            end else if (rx_tlast && r_state != S_IDLE) begin
                r_rx_seen <= 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_stop_latched <= 1'b0;
            end else if (stop_req) begin
                r_stop_latched <= 1'b1;
            end

            if (r_state == S_WAIT_RX && w_ack) begin
                r_run_count <= r_run_count + 16'd1;
            end
        end
    end

    // Frame memory survives reset; it is only writable while idle.
    always_ff @(posedge axis_aclk) begin
        if (wr_en && r_state == S_IDLE && wr_addr <= LAST_ADDR) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign m_axis_tstrb  = '1;
    assign m_axis_tvalid = (r_state == S_STREAM);
    assign m_axis_tlast  = m_axis_tvalid &
                           (w_frame_end | ((TLAST_PER_PACKET != 0) && w_pkt_end));
    assign busy          = (r_state != S_IDLE);
    assign run_count     = r_run_count;

endmodule
